// File: rtl/digdug_io06xx_if.sv
// Device-bus and custom-chip side signals of the Namco 06XX I/O bridge.
interface digdug_io06xx_if;
    logic [15:0] dev_ad;
    logic        dev_rd;
    logic        dev_wr;
    logic [7:0]  dev_di;
    logic        dev_dv;
    logic [7:0]  dev_do;
    logic [3:0]  chip_sel;
    logic        chip_wr;
    logic        chip_rd;
    logic [7:0]  chip_di;
    logic [31:0] chip_do;
    logic        nmi_req;

    modport master (
        output dev_ad, dev_rd, dev_wr, dev_di, chip_do,
        input  dev_dv, dev_do, chip_sel, chip_wr, chip_rd, chip_di, nmi_req
    );

    modport slave (
        input  dev_ad, dev_rd, dev_wr, dev_di, chip_do,
        output dev_dv, dev_do, chip_sel, chip_wr, chip_rd, chip_di, nmi_req
    );
endinterface

// File: rtl/digdug_io06xx.sv
// Namco 06XX bridge: decodes the 0x70xx/0x71xx windows, forwards single strobes
// to the custom chips and generates the periodic NMI request for CPU0.
module digdug_io06xx #(
    parameter int SLOT_LEN     = 2,
    parameter int NMI_PRESCALE = 4800
) (
    input logic            i_clk,
    input logic            i_reset,
    digdug_io06xx_if.slave io_bus
);
    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_ACT     = 2'd1;
    localparam logic [1:0]  S_HOLD    = 2'd2;
    localparam logic [15:0] PRE_LAST  = 16'(NMI_PRESCALE - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(SLOT_LEN - 3);

    logic [1:0]  r_state;
    logic [7:0]  r_hold;
    logic [7:0]  r_ctrl;
    logic [7:0]  r_chipDi;
    logic        r_chipWr;
    logic        r_chipRd;
    logic        r_rdPend;
    logic        r_rdCtrl;
    logic        r_devDv;
    logic [7:0]  r_devDo;
    logic [15:0] r_pre;
    logic [2:0]  r_unit;
    logic        r_nmi;

    logic        w_dataHit;
    logic        w_ctrlHit;
    logic        w_access;
    logic        w_ctrlWrite;
    logic [7:0]  w_rdByte;
    logic        w_unused;

    assign w_dataHit   = (io_bus.dev_ad[15:8] == 8'h70);
    assign w_ctrlHit   = (io_bus.dev_ad[15:8] == 8'h71);
    assign w_access    = (io_bus.dev_rd | io_bus.dev_wr) & (w_dataHit | w_ctrlHit);
    assign w_ctrlWrite = (r_state == S_IDLE) & w_access & io_bus.dev_wr & w_ctrlHit;
    assign w_unused    = &{1'b0, io_bus.dev_ad[7:0]};

    // Lowest selected chip answers a read; nothing selected or write direction reads as open bus.
    always_comb begin
        w_rdByte = 8'hFF;
        if (r_ctrl[4]) begin
            casez (r_ctrl[3:0])
                4'b???1: w_rdByte = io_bus.chip_do[7:0];
                4'b??10: w_rdByte = io_bus.chip_do[15:8];
                4'b?100: w_rdByte = io_bus.chip_do[23:16];
                4'b1000: w_rdByte = io_bus.chip_do[31:24];
                default: w_rdByte = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_IDLE;
            r_hold   <= 8'd0;
            r_ctrl   <= 8'h10;
            r_chipDi <= 8'd0;
            r_chipWr <= 1'b0;
            r_chipRd <= 1'b0;
            r_rdPend <= 1'b0;
            r_rdCtrl <= 1'b0;
            r_devDv  <= 1'b0;
            r_devDo  <= 8'd0;
        end else begin
            r_chipWr <= 1'b0;
            r_chipRd <= 1'b0;
            r_devDv  <= 1'b0;
            r_devDo  <= 8'd0;
            if (r_state == S_ACT && r_rdPend) begin
                r_devDv <= 1'b1;
                r_devDo <= r_rdCtrl ? r_ctrl : w_rdByte;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_access) begin
                        r_state  <= S_ACT;
                        r_hold   <= 8'd0;
                        r_rdPend <= io_bus.dev_rd & ~io_bus.dev_wr;
                        r_rdCtrl <= w_ctrlHit;
                        if (io_bus.dev_wr) begin
                            if (w_ctrlHit) begin
                                r_ctrl <= io_bus.dev_di;
                            end else begin
                                r_chipDi <= io_bus.dev_di;
                                r_chipWr <= (r_ctrl[3:0] != 4'd0) & ~r_ctrl[4];
                            end
                        end else if (w_dataHit) begin
                            r_chipRd <= 1'b1;
                        end
                    end
                end
                S_ACT: begin
                    r_state <= (SLOT_LEN > 2) ? S_HOLD : S_IDLE;
                end
                S_HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Any CTRL write restarts the NMI phase, even when the period code is unchanged.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pre  <= 16'd0;
            r_unit <= 3'd0;
            r_nmi  <= 1'b0;
        end else begin
            r_nmi <= 1'b0;
            if (w_ctrlWrite || r_ctrl[7:5] == 3'd0) begin
                r_pre  <= 16'd0;
                r_unit <= 3'd0;
            end else if (r_pre == PRE_LAST) begin
                r_pre <= 16'd0;
                if (r_unit + 3'd1 == r_ctrl[7:5]) begin
                    r_nmi  <= 1'b1;
                    r_unit <= 3'd0;
                end else begin
                    r_unit <= r_unit + 3'd1;
                end
            end else begin
                r_pre <= r_pre + 16'd1;
            end
        end
    end

    assign io_bus.dev_dv   = r_devDv;
    assign io_bus.dev_do   = r_devDo;
    assign io_bus.chip_sel = r_ctrl[3:0];
    assign io_bus.chip_wr  = r_chipWr;
    assign io_bus.chip_rd  = r_chipRd;
    assign io_bus.chip_di  = r_chipDi;
    assign io_bus.nmi_req  = r_nmi;
endmodule

// File: tb/tb_digdug_io06xx.sv
// Randomised and directed bench for digdug_io06xx against a cycle-keyed expectation model.
module tb_digdug_io06xx;
    localparam int P = 10;

    typedef struct packed {
        bit       wr;
        bit [7:0] di;
        bit       rd;
        bit       dv;
        bit [7:0] dout;
        bit       ctrlChg;
        bit [7:0] ctrl;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    int         cyc      = 0;
    int         nChecks  = 0;
    int         nPass    = 0;
    exp_t       expAt[int];
    logic [7:0] archCtrl = 8'h10;
    logic [7:0] mCtrl    = 8'h10;
    int         nmiStart = 0;
    int         wrCount  = 0;
    int         rdCount  = 0;
    int         dvCount  = 0;
    logic [7:0] lastDo   = 8'h00;
    logic [7:0] wrData[$];
    int         nmiTimes[$];

    digdug_io06xx_if bus();

    digdug_io06xx #(.SLOT_LEN(2), .NMI_PRESCALE(P)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        nChecks++;
        if (act === want) nPass++;
        else $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, want);
    endtask

    function automatic exp_t getExp(input int k);
        return expAt.exists(k) ? expAt[k] : exp_t'(0);
    endfunction

    function automatic logic [7:0] chipByte(input logic [7:0] ctrl, input logic [31:0] dout);
        if (!ctrl[4]) return 8'hFF;
        for (int i = 0; i < 4; i++) begin
            if (ctrl[i]) return dout[8*i +: 8];
        end
        return 8'hFF;
    endfunction

    // The only process comparing DUT outputs with the model, every cycle after the first reset edge.
    always @(negedge clk) begin : compare
        exp_t e;
        int   period;
        bit   eNmi;
        if (cyc >= 1) begin
            e = getExp(cyc);
            if (e.ctrlChg) begin
                mCtrl    = e.ctrl;
                nmiStart = cyc;
            end
            period = int'(mCtrl[7:5]) * P;
            eNmi   = (period != 0) && (cyc > nmiStart) && (((cyc - nmiStart) % period) == 0);
            checkOutput("chip_sel", 32'(bus.chip_sel), 32'(mCtrl[3:0]));
            checkOutput("chip_wr", 32'(bus.chip_wr), 32'(e.wr));
            if (e.wr) checkOutput("chip_di", 32'(bus.chip_di), 32'(e.di));
            checkOutput("chip_rd", 32'(bus.chip_rd), 32'(e.rd));
            checkOutput("dev_dv", 32'(bus.dev_dv), 32'(e.dv));
            checkOutput("dev_do", 32'(bus.dev_do), e.dv ? 32'(e.dout) : 32'h0);
            checkOutput("nmi_req", 32'(bus.nmi_req), 32'(eNmi));
            if (bus.chip_wr === 1'b1) begin
                wrCount++;
                wrData.push_back(bus.chip_di);
            end
            if (bus.chip_rd === 1'b1) rdCount++;
            if (bus.dev_dv === 1'b1) begin
                dvCount++;
                lastDo = bus.dev_do;
            end
            if (bus.nmi_req === 1'b1) nmiTimes.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic busIdle();
        bus.dev_ad = 16'h0000;
        bus.dev_rd = 1'b0;
        bus.dev_wr = 1'b0;
        bus.dev_di = 8'h00;
    endtask

    // Drives one bus access for 'hold' cycles and records what it must cause.
    task automatic applyStimulus(input logic [15:0] ad, input bit rd, input bit wr,
                                 input logic [7:0] di, input int hold);
        int   c;
        exp_t e;
        bit   hitD;
        bit   hitC;
        c = cyc;
        bus.dev_ad = ad;
        bus.dev_rd = rd;
        bus.dev_wr = wr;
        bus.dev_di = di;
        hitD = (ad[15:8] == 8'h70);
        hitC = (ad[15:8] == 8'h71);
        if ((rd || wr) && (hitD || hitC)) begin
            if (wr && hitC) begin
                archCtrl  = di;
                e         = getExp(c + 1);
                e.ctrlChg = 1'b1;
                e.ctrl    = di;
                expAt[c + 1] = e;
            end else if (wr) begin
                if (archCtrl[3:0] != 4'd0 && !archCtrl[4]) begin
                    e    = getExp(c + 1);
                    e.wr = 1'b1;
                    e.di = di;
                    expAt[c + 1] = e;
                end
            end else if (hitC) begin
                e      = getExp(c + 2);
                e.dv   = 1'b1;
                e.dout = archCtrl;
                expAt[c + 2] = e;
            end else begin
                e    = getExp(c + 1);
                e.rd = 1'b1;
                expAt[c + 1] = e;
                e      = getExp(c + 2);
                e.dv   = 1'b1;
                e.dout = chipByte(archCtrl, bus.chip_do);
                expAt[c + 2] = e;
            end
        end
        tick(hold);
        busIdle();
    endtask

    task automatic applyReset(input int n);
        int   c;
        int   stale[$];
        exp_t e;
        busIdle();
        reset = 1'b1;
        c = cyc;
        foreach (expAt[k]) if (k > c) stale.push_back(k);
        foreach (stale[i]) expAt.delete(stale[i]);
        archCtrl  = 8'h10;
        e         = '0;
        e.ctrlChg = 1'b1;
        e.ctrl    = 8'h10;
        expAt[c + 1] = e;
        tick(n);
        reset = 1'b0;
    endtask

    initial begin
        int d0;
        int w0;
        int r0;
        int n0;
        int q0;
        int c0;
        busIdle();
        bus.chip_do = 32'h0;
        applyReset(3);

        d0 = dvCount;
        applyStimulus(16'h7100, 1'b1, 1'b0, 8'h00, 2);
        tick(2);
        checkOutput("reset_ctrl_read_dv", 32'(dvCount - d0), 32'd1);
        checkOutput("reset_ctrl_read_val", 32'(lastDo), 32'h10);
        tick(200);
        checkOutput("nmi_stopped_after_reset", 32'(nmiTimes.size()), 32'd0);

        applyStimulus(16'h7100, 1'b0, 1'b1, 8'h31, 2);
        w0 = wrCount;
        applyStimulus(16'h7000, 1'b0, 1'b1, 8'hA5, 2);
        tick(2);
        checkOutput("write_dropped_read_dir", 32'(wrCount - w0), 32'd0);
        applyStimulus(16'h7100, 1'b0, 1'b1, 8'h01, 2);
        w0 = wrCount;
        applyStimulus(16'h7000, 1'b0, 1'b1, 8'hA5, 2);
        tick(2);
        checkOutput("single_write_count", 32'(wrCount - w0), 32'd1);
        checkOutput("single_write_data", 32'(wrData[wrData.size() - 1]), 32'hA5);
        checkOutput("single_write_sel", 32'(bus.chip_sel), 32'h1);

        applyStimulus(16'h7100, 1'b0, 1'b1, 8'h14, 2);
        bus.chip_do = 32'h33221100;
        r0 = rdCount;
        d0 = dvCount;
        applyStimulus(16'h7000, 1'b1, 1'b0, 8'h00, 2);
        tick(2);
        checkOutput("chip_read_rd_count", 32'(rdCount - r0), 32'd1);
        checkOutput("chip_read_dv_count", 32'(dvCount - d0), 32'd1);
        checkOutput("chip_read_value", 32'(lastDo), 32'h22);
        applyStimulus(16'h7100, 1'b0, 1'b1, 8'h10, 2);
        applyStimulus(16'h7000, 1'b1, 1'b0, 8'h00, 2);
        tick(2);
        checkOutput("chip_read_none_sel", 32'(lastDo), 32'hFF);

        n0 = nmiTimes.size();
        c0 = cyc;
        applyStimulus(16'h7100, 1'b0, 1'b1, 8'h61, 2);
        tick(100);
        checkOutput("nmi_pulse_count", 32'(nmiTimes.size() - n0), 32'd3);
        checkOutput("nmi_first_pulse", 32'(nmiTimes[n0]), 32'(c0 + 31));
        checkOutput("nmi_period", 32'(nmiTimes[n0 + 1] - nmiTimes[n0]), 32'd30);
        applyStimulus(16'h7100, 1'b0, 1'b1, 8'h01, 2);
        n0 = nmiTimes.size();
        tick(100);
        checkOutput("nmi_stopped_by_ctrl", 32'(nmiTimes.size() - n0), 32'd0);
        applyStimulus(16'h7100, 1'b0, 1'b1, 8'h61, 2);
        tick(15);
        n0 = nmiTimes.size();
        c0 = cyc;
        applyStimulus(16'h7100, 1'b0, 1'b1, 8'h61, 2);
        tick(40);
        checkOutput("nmi_rewrite_restarts", 32'(nmiTimes[n0]), 32'(c0 + 31));

        applyStimulus(16'h7100, 1'b0, 1'b1, 8'h01, 2);
        w0 = wrCount;
        q0 = wrData.size();
        applyStimulus(16'h7000, 1'b0, 1'b1, 8'h5A, 2);
        applyStimulus(16'h7000, 1'b0, 1'b1, 8'hC3, 2);
        tick(2);
        checkOutput("b2b_write_count", 32'(wrCount - w0), 32'd2);
        checkOutput("b2b_write_first", 32'(wrData[q0]), 32'h5A);
        checkOutput("b2b_write_second", 32'(wrData[q0 + 1]), 32'hC3);

        applyStimulus(16'h7100, 1'b0, 1'b1, 8'h14, 2);
        d0 = dvCount;
        applyStimulus(16'h7000, 1'b1, 1'b0, 8'h00, 1);
        applyReset(2);
        tick(3);
        checkOutput("reset_mid_read_no_dv", 32'(dvCount - d0), 32'd0);
        checkOutput("reset_mid_read_sel", 32'(bus.chip_sel), 32'h0);
        applyStimulus(16'h7100, 1'b1, 1'b0, 8'h00, 2);
        tick(2);
        checkOutput("reset_mid_read_ctrl", 32'(lastDo), 32'h10);

        for (int i = 0; i < 400; i++) begin
            int         kind;
            logic [7:0] hi;
            logic [7:0] lo;
            logic [7:0] di;
            kind        = int'($urandom_range(0, 8));
            lo          = 8'($urandom());
            di          = 8'($urandom());
            bus.chip_do = $urandom();
            case (kind)
                0: tick(int'($urandom_range(1, 3)));
                1: applyStimulus({8'h71, lo}, 1'($urandom()), 1'b1, di, 2);
                2: applyStimulus({8'h71, lo}, 1'b1, 1'b0, di, 2);
                3, 4: applyStimulus({8'h70, lo}, 1'($urandom()), 1'b1, di, 2);
                5, 6: applyStimulus({8'h70, lo}, 1'b1, 1'b0, di, 2);
                7: begin
                    hi = 8'($urandom());
                    if (hi == 8'h70 || hi == 8'h71) hi = 8'h72;
                    applyStimulus({hi, lo}, 1'($urandom()), 1'($urandom()), di, 2);
                end
                default: begin
                    if ($urandom_range(0, 7) == 0) begin
                        applyStimulus({8'h70, lo}, 1'b1, 1'b0, di, 1);
                        applyReset(1);
                    end else begin
                        tick(1);
                    end
                end
            endcase
        end

        tick(5);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
